// File: rtl/tcam_route_mem_if.sv
// Command, read-back and compare-response bundle for tcam_route_mem.
// The DUT-side modport exports the FSM state on scan_active for checkers.
interface tcam_route_mem_if #(
    parameter int KEY_W        = 8,
    parameter int Words        = 16,
    parameter int ID_Width     = 4,
    parameter int Weight_Width = 4
);
    localparam int AddressSize = $clog2(Words);

    logic [2:0]              MODE;
    logic                    Cmd_Valid;
    logic                    Cmd_Ready;
    logic [AddressSize-1:0]  A_In;
    logic [KEY_W-1:0]        Data_In;
    logic [KEY_W-1:0]        Mskb_In;
    logic                    Dcs_In;
    logic                    Vbe_In;
    logic                    Vbi_In;
    logic [ID_Width-1:0]     DstID_In;
    logic [Weight_Width-1:0] Weight_In;
    logic [KEY_W-1:0]        Do_Out;
    logic                    Vbo_Out;
    logic                    Rd_Valid;
    logic                    Out_Valid;
    logic                    Out_Ready;
    logic                    Out_Hit;
    logic                    Out_Last;
    logic [AddressSize-1:0]  Hit_Addr;
    logic [ID_Width-1:0]     DstID_Out;
    logic [Weight_Width-1:0] Weight_Out;
    logic                    scan_active;

    // Handshakes: a command moves on a clk edge where Cmd_Valid & Cmd_Ready;
    // a response moves on an edge where Out_Valid & Out_Ready, and while
    // Out_Valid is high and Out_Ready low every Out_* signal holds its value.
    modport master (
        output MODE, Cmd_Valid, A_In, Data_In, Mskb_In, Dcs_In, Vbe_In, Vbi_In,
               DstID_In, Weight_In, Out_Ready,
        input  Cmd_Ready, Do_Out, Vbo_Out, Rd_Valid, Out_Valid, Out_Hit, Out_Last,
               Hit_Addr, DstID_Out, Weight_Out, scan_active
    );

    modport slave (
        input  MODE, Cmd_Valid, A_In, Data_In, Mskb_In, Dcs_In, Vbe_In, Vbi_In,
               DstID_In, Weight_In, Out_Ready,
        output Cmd_Ready, Do_Out, Vbo_Out, Rd_Valid, Out_Valid, Out_Hit, Out_Last,
               Hit_Addr, DstID_Out, Weight_Out, scan_active
    );
endinterface

// File: rtl/tcam_route_mem.sv
// Ternary routing memory: masked key compare returning every hit, lowest
// address first, one response per handshake (multicast fan-out).
module tcam_route_mem #(
    parameter int KEY_W        = 8,
    parameter int Words        = 16,
    parameter int ID_Width     = 4,
    parameter int Weight_Width = 4
) (
    input logic             clk,
    input logic             rst,
    tcam_route_mem_if.slave bus
);
    localparam int AddressSize = $clog2(Words);
    localparam logic [AddressSize:0] WORDS_LIM = (AddressSize+1)'(Words);

    localparam logic [2:0] MODE_W   = 3'b001;
    localparam logic [2:0] MODE_R   = 3'b010;
    localparam logic [2:0] MODE_F   = 3'b011;
    localparam logic [2:0] MODE_C   = 3'b100;
    localparam logic [2:0] MODE_RST = 3'b101;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;
    state_t state_q, state_d;

    logic [KEY_W-1:0]        data_q [Words];
    logic [KEY_W-1:0]        care_q [Words];
    logic [ID_Width-1:0]     dst_q  [Words];
    logic [Weight_Width-1:0] wt_q   [Words];
    logic [Words-1:0]        valid_q;
    logic [Words-1:0]        pending_q;
    logic [Words-1:0]        hit_vec;
    logic [Words-1:0]        rest_vec;
    logic                    miss_q;
    logic [KEY_W-1:0]        do_q;
    logic                    vbo_q;
    logic                    rd_valid_q;
    logic [AddressSize-1:0]  low_idx;
    logic                    pick_found;

    logic                    cmd_ready;
    logic                    out_valid;
    logic                    out_hit;
    logic                    out_last;
    logic [AddressSize-1:0]  hit_addr;
    logic [ID_Width-1:0]     dst_out;
    logic [Weight_Width-1:0] wt_out;

    logic accept, clr, in_range, fire, last;

    assign accept   = bus.Cmd_Valid && cmd_ready;
    assign clr      = rst || (accept && (bus.MODE == MODE_RST));
    assign in_range = ({1'b0, bus.A_In} < WORDS_LIM);
    assign fire     = (state_q == SCAN) && bus.Out_Ready;
    assign last     = miss_q || (rest_vec == '0);

    // A set care bit only counts where the global search mask also selects it.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < Words; i++) begin
            hit_vec[i] = valid_q[i] &&
                         (((data_q[i] ^ bus.Data_In) & care_q[i] & bus.Mskb_In) == '0);
        end
    end

    always_comb begin
        pick_found = 1'b0;
        low_idx    = '0;
        rest_vec   = pending_q;
        for (int i = 0; i < Words; i++) begin
            if (!pick_found && pending_q[i]) begin
                pick_found  = 1'b1;
                low_idx     = AddressSize'(i);
                rest_vec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && (bus.MODE == MODE_C)) state_d = SCAN;
            SCAN: if (fire && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        out_valid = 1'b0;
        out_hit   = 1'b0;
        out_last  = 1'b0;
        hit_addr  = '0;
        dst_out   = '0;
        wt_out    = '0;
        case (state_q)
            IDLE: cmd_ready = 1'b1;
            SCAN: begin
                out_valid = 1'b1;
                out_last  = last;
                if (!miss_q) begin
                    out_hit  = 1'b1;
                    hit_addr = low_idx;
                    dst_out  = dst_q[low_idx];
                    wt_out   = wt_q[low_idx];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q    <= '0;
            pending_q  <= '0;
            miss_q     <= 1'b0;
            do_q       <= '0;
            vbo_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < Words; i++) begin
                data_q[i] <= '0;
                care_q[i] <= '0;
                dst_q[i]  <= '0;
                wt_q[i]   <= '0;
            end
        end else begin
            rd_valid_q <= 1'b0;
            if (accept) begin
                case (bus.MODE)
                    MODE_W: if (in_range) begin
                        if (bus.Dcs_In) begin
                            data_q[bus.A_In] <= bus.Data_In;
                            dst_q[bus.A_In]  <= bus.DstID_In;
                            wt_q[bus.A_In]   <= bus.Weight_In;
                        end else begin
                            care_q[bus.A_In] <= bus.Data_In;
                        end
                        if (bus.Vbe_In) valid_q[bus.A_In] <= bus.Vbi_In;
                    end
                    MODE_R: begin
                        rd_valid_q <= 1'b1;
                        if (in_range) begin
                            do_q  <= bus.Dcs_In ? data_q[bus.A_In] : care_q[bus.A_In];
                            vbo_q <= bus.Vbe_In && valid_q[bus.A_In];
                        end else begin
                            do_q  <= '0;
                            vbo_q <= 1'b0;
                        end
                    end
                    MODE_F: valid_q <= '0;
                    MODE_C: begin
                        pending_q <= hit_vec;
                        miss_q    <= (hit_vec == '0);
                    end
                    default: ;
                endcase
            end
            // Commands are never accepted in SCAN, so this cannot race the capture.
            if (fire) pending_q <= rest_vec;
        end
    end

    assign bus.Cmd_Ready   = cmd_ready;
    assign bus.Do_Out      = do_q;
    assign bus.Vbo_Out     = vbo_q;
    assign bus.Rd_Valid    = rd_valid_q;
    assign bus.Out_Valid   = out_valid;
    assign bus.Out_Hit     = out_hit;
    assign bus.Out_Last    = out_last;
    assign bus.Hit_Addr    = hit_addr;
    assign bus.DstID_Out   = dst_out;
    assign bus.Weight_Out  = wt_out;
    assign bus.scan_active = (state_q == SCAN);
endmodule

// File: tb/tb_tcam_route_mem.sv
// Bench for tcam_route_mem: directed scenarios then random traffic, scored
// against an array model of the table and a queue of expected hit addresses.
module tb_tcam_route_mem;
    localparam int KW = 8;
    localparam int NW = 16;
    localparam int AW = 4;
    localparam int IW = 4;
    localparam int WW = 4;

    localparam logic [2:0] M_I   = 3'b000;
    localparam logic [2:0] M_W   = 3'b001;
    localparam logic [2:0] M_R   = 3'b010;
    localparam logic [2:0] M_F   = 3'b011;
    localparam logic [2:0] M_C   = 3'b100;
    localparam logic [2:0] M_RST = 3'b101;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    tcam_route_mem_if #(.KEY_W(KW), .Words(NW), .ID_Width(IW), .Weight_Width(WW)) bus ();

    tcam_route_mem #(.KEY_W(KW), .Words(NW), .ID_Width(IW), .Weight_Width(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [KW-1:0] m_data [NW];
    logic [KW-1:0] m_care [NW];
    logic [IW-1:0] m_dst  [NW];
    logic [WW-1:0] m_wt   [NW];
    logic          m_valid[NW];
    logic [AW-1:0] exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_data[i] = '0; m_care[i] = '0; m_dst[i] = '0; m_wt[i] = '0; m_valid[i] = 1'b0;
        end
    endtask

    // Expected responses: every valid entry whose cared, searched bits equal the key.
    task automatic model_search(input logic [KW-1:0] key, input logic [KW-1:0] mskb);
        exp_q.delete();
        for (int i = 0; i < NW; i++) begin
            bit ok;
            ok = m_valid[i];
            for (int b = 0; b < KW; b++)
                if (m_care[i][b] && mskb[b] && (m_data[i][b] != key[b])) ok = 0;
            if (ok) exp_q.push_back(AW'(i));
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic [2:0] mode);
        int w;
        @(negedge clk);
        bus.MODE      = mode;
        bus.Cmd_Valid = 1'b1;
        w = 0;
        while (bus.Cmd_Ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready", bus.Cmd_Ready, 1);
        @(posedge clk);
        #1 bus.Cmd_Valid = 1'b0;
    endtask

    task automatic do_write(input int addr, input bit dcs, input logic [KW-1:0] data,
                            input bit vbe, input bit vbi, input logic [IW-1:0] dst,
                            input logic [WW-1:0] wt);
        bus.A_In = AW'(addr); bus.Dcs_In = dcs; bus.Data_In = data;
        bus.Vbe_In = vbe; bus.Vbi_In = vbi; bus.DstID_In = dst; bus.Weight_In = wt;
        send(M_W);
        if (dcs) begin
            m_data[addr] = data; m_dst[addr] = dst; m_wt[addr] = wt;
        end else begin
            m_care[addr] = data;
        end
        if (vbe) m_valid[addr] = vbi;
    endtask

    task automatic do_read(input int addr, input bit dcs, input bit vbe);
        logic [KW-1:0] e_do;
        bit e_vb;
        bus.A_In = AW'(addr); bus.Dcs_In = dcs; bus.Vbe_In = vbe;
        send(M_R);
        e_do = dcs ? m_data[addr] : m_care[addr];
        e_vb = vbe && m_valid[addr];
        @(negedge clk);
        check("rd_valid", bus.Rd_Valid, 1);
        check("do_out", bus.Do_Out, e_do);
        check("vbo_out", bus.Vbo_Out, e_vb);
        @(negedge clk);
        check("rd_valid_pulse", bus.Rd_Valid, 0);
        check("do_out_hold", bus.Do_Out, e_do);
    endtask

    task automatic do_flush();
        send(M_F);
        for (int i = 0; i < NW; i++) m_valid[i] = 1'b0;
    endtask

    // rdy_rand=0 keeps Out_Ready high; stall holds it low for the first 3 cycles;
    // inject_w presents a write for the whole scan, which must stay unaccepted.
    task automatic do_compare(input logic [KW-1:0] key, input logic [KW-1:0] mskb,
                              input bit rdy_rand, input bit stall, input bit inject_w);
        bit miss, done, rdy, e_last;
        int budget, stalls;
        logic [AW-1:0] e_addr;
        bus.Data_In = key; bus.Mskb_In = mskb;
        model_search(key, mskb);
        miss = (exp_q.size() == 0);
        send(M_C);
        if (inject_w) begin
            bus.MODE = M_W; bus.A_In = AW'(3); bus.Dcs_In = 1'b1; bus.Data_In = 8'hFF;
            bus.Vbe_In = 1'b1; bus.Vbi_In = 1'b1; bus.Cmd_Valid = 1'b1;
        end
        stalls = stall ? 3 : 0;
        done = 0;
        budget = 0;
        while (!done && budget < 200) begin
            @(negedge clk);
            budget++;
            e_addr = miss ? '0 : exp_q[0];
            e_last = miss || (exp_q.size() == 1);
            check("out_valid", bus.Out_Valid, 1);
            check("out_hit", bus.Out_Hit, !miss);
            check("hit_addr", bus.Hit_Addr, e_addr);
            check("out_last", bus.Out_Last, e_last);
            check("dst_out", bus.DstID_Out, miss ? '0 : m_dst[e_addr]);
            check("weight_out", bus.Weight_Out, miss ? '0 : m_wt[e_addr]);
            check("scan_cmd_ready", bus.Cmd_Ready, 0);
            if (stalls > 0) begin
                rdy = 0;
                stalls--;
            end else begin
                rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            bus.Out_Ready = rdy;
            if (rdy) begin
                if (!miss) void'(exp_q.pop_front());
                if (e_last) done = 1;
            end
        end
        check("scan_done_in_budget", done, 1);
        @(negedge clk);
        bus.Cmd_Valid = 1'b0;
        bus.Out_Ready = 1'b0;
        check("post_scan_valid", bus.Out_Valid, 0);
        check("post_scan_cmd_ready", bus.Cmd_Ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [KW-1:0] keys [4];
        logic [KW-1:0] cares [4];
        logic [KW-1:0] kd;
        int op, a;

        n_tests = 0;
        n_fail  = 0;
        keys[0] = 8'hA0; keys[1] = 8'h5A; keys[2] = 8'h3C; keys[3] = 8'hAF;
        cares[0] = 8'hFF; cares[1] = 8'hF0; cares[2] = 8'h0F; cares[3] = 8'h00;
        bus.MODE = M_I; bus.Cmd_Valid = 0; bus.A_In = '0; bus.Data_In = '0; bus.Mskb_In = '0;
        bus.Dcs_In = 0; bus.Vbe_In = 0; bus.Vbi_In = 0; bus.DstID_In = '0; bus.Weight_In = '0;
        bus.Out_Ready = 0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        @(negedge clk);
        check("rst_cmd_ready", bus.Cmd_Ready, 1);
        check("rst_out_valid", bus.Out_Valid, 0);
        check("rst_out_hit", bus.Out_Hit, 0);
        check("rst_out_last", bus.Out_Last, 0);
        check("rst_hit_addr", bus.Hit_Addr, 0);
        check("rst_dst", bus.DstID_Out, 0);
        check("rst_weight", bus.Weight_Out, 0);
        check("rst_rd_valid", bus.Rd_Valid, 0);
        check("rst_do_out", bus.Do_Out, 0);
        do_read(1, 1, 1);

        // Single exact-match hit.
        do_write(1, 1, 8'h5A, 1, 1, 4'd3, 4'd7);
        do_write(1, 0, 8'hFF, 0, 0, 4'd0, 4'd0);
        do_compare(8'h5A, 8'hFF, 0, 0, 0);

        // Multicast over entries 2, 5, 9 with low-nibble don't-care.
        do_write(2, 1, 8'hA0, 1, 1, 4'd2, 4'd12);
        do_write(5, 1, 8'hA0, 1, 1, 4'd5, 4'd9);
        do_write(9, 1, 8'hA0, 1, 1, 4'd9, 4'd1);
        do_write(2, 0, 8'hF0, 0, 0, 4'd0, 4'd0);
        do_write(5, 0, 8'hF0, 0, 0, 4'd0, 4'd0);
        do_write(9, 0, 8'hF0, 0, 0, 4'd0, 4'd0);
        do_compare(8'hAF, 8'hFF, 0, 0, 0);
        do_compare(8'hAF, 8'hFF, 0, 1, 1);
        do_read(3, 1, 1);

        // Flush leaves only misses.
        do_flush();
        do_compare(8'hAF, 8'hFF, 0, 0, 0);
        do_read(5, 1, 1);

        // Reset in the middle of a scan.
        do_write(2, 1, 8'hA0, 1, 1, 4'd2, 4'd12);
        do_write(5, 1, 8'hA0, 1, 1, 4'd5, 4'd9);
        do_write(9, 1, 8'hA0, 1, 1, 4'd9, 4'd1);
        bus.Data_In = 8'hAF; bus.Mskb_In = 8'hFF;
        send(M_C);
        @(negedge clk);
        check("abort_first_addr", bus.Hit_Addr, 2);
        check("abort_first_last", bus.Out_Last, 0);
        bus.Out_Ready = 1'b1;
        @(negedge clk);
        check("abort_second_addr", bus.Hit_Addr, 5);
        bus.Out_Ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("abort_out_valid", bus.Out_Valid, 0);
        check("abort_cmd_ready", bus.Cmd_Ready, 1);
        do_compare(8'hAF, 8'hFF, 0, 0, 0);

        // RST command clears table and read-back registers.
        do_write(4, 1, 8'h3C, 1, 1, 4'd4, 4'd4);
        do_read(4, 1, 1);
        send(M_RST);
        model_reset();
        @(negedge clk);
        check("cmdrst_do_out", bus.Do_Out, 0);
        check("cmdrst_cmd_ready", bus.Cmd_Ready, 1);
        do_read(4, 1, 1);

        // Random traffic.
        for (int n = 0; n < 160; n++) begin
            op = $urandom_range(0, 9);
            a  = $urandom_range(0, NW - 1);
            if (op <= 3) begin
                if ($urandom_range(0, 1) == 1)
                    do_write(a, 1, keys[$urandom_range(0, 3)], $urandom_range(0, 1),
                             $urandom_range(0, 3) != 0, IW'($urandom_range(0, 15)),
                             WW'($urandom_range(0, 15)));
                else
                    do_write(a, 0, cares[$urandom_range(0, 3)], $urandom_range(0, 1),
                             $urandom_range(0, 3) != 0, '0, '0);
            end else if (op <= 5) begin
                do_read(a, $urandom_range(0, 1), $urandom_range(0, 1));
            end else if (op <= 7) begin
                kd = ($urandom_range(0, 3) == 0) ? KW'($urandom_range(0, 255)) : m_data[a];
                do_compare(kd, ($urandom_range(0, 2) == 0) ? KW'($urandom_range(0, 255)) : 8'hFF,
                           1, 0, 0);
            end else if (op == 8) begin
                if ($urandom_range(0, 3) == 0) do_flush();
                else begin
                    bus.A_In = AW'(a); bus.Dcs_In = 1'b1; bus.Vbe_In = 1'b1; bus.Vbi_In = 1'b0;
                    send(($urandom_range(0, 1) == 0) ? M_I : 3'(6 + $urandom_range(0, 1)));
                end
            end else begin
                if ($urandom_range(0, 7) == 0) begin
                    send(M_RST);
                    model_reset();
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tcam_route_mem.md
Name: tcam_route_mem

Overview:
- Parametrised TCAM routing memory for the neuromorphic packet router.
- Each entry holds a key, a per-bit care mask, a valid bit and a routing payload (destination ID and weight).
- A compare returns every matching entry, one per cycle, lowest address first, with valid/ready back-pressure. This provides multicast fan-out, which the single-hit Mem block does not.
- Sits between the spike packet input and the router output stage.

Parameters:
KEY_W, 8, key width: {PacketID, Axon, Synapse}
Words, 16, number of entries (need not be a power of 2)
AddressSize, $clog2(Words), address width (derived; do not override)
ID_Width, 4, destination ID payload width
Weight_Width, 4, weight payload width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
MODE  in  3  command: I=000, W=001, R=010, F=011, C=100, RST=101
Cmd_Valid  in  1  command strobe
Cmd_Ready  out  1  command accepted when Cmd_Valid & Cmd_Ready
A_In  in  AddressSize  entry address for W/R
Data_In  in  KEY_W  W: key or care word; C: search key
Mskb_In  in  KEY_W  C: global search mask, 1 = bit participates
Dcs_In  in  1  W/R plane select: 1 = data plane, 0 = care plane
Vbe_In  in  1  W: valid-bit write enable; R: return valid bit
Vbi_In  in  1  W: valid-bit value
DstID_In  in  ID_Width  W (Dcs_In=1): destination payload
Weight_In  in  Weight_Width  W (Dcs_In=1): weight payload
Do_Out  out  KEY_W  read data
Vbo_Out  out  1  read valid bit
Rd_Valid  out  1  one-cycle pulse, read data valid
Out_Valid  out  1  compare response valid
Out_Ready  in  1  compare response consumed
Out_Hit  out  1  1 = hit response, 0 = miss response
Out_Last  out  1  last response of the current compare
Hit_Addr  out  AddressSize  matching entry address
DstID_Out  out  ID_Width  payload of matching entry
Weight_Out  out  Weight_Width  payload of matching entry

Behaviour:
- Reset (rst=1 at a clk edge):
  - All valid bits, data, care, payload storage and pending-hit vector cleared; FSM to IDLE.
  - Every output 0, except Cmd_Ready = 1 from the first cycle after reset.
  - rst has priority over any command or scan in flight. A scan is abandoned and Out_Valid is 0 on the next cycle.
- FSM states:
  - IDLE: Cmd_Ready=1.
  - SCAN: Cmd_Ready=0, responses being emitted.
  - IDLE→SCAN on an accepted C. SCAN→IDLE on the handshake (Out_Valid & Out_Ready) of the response with Out_Last=1.
- Write (W, accepted):
  - Dcs_In=1 writes data[A_In] = Data_In, plus DstID/Weight payload.
  - Dcs_In=0 writes care[A_In] = Data_In.
  - If Vbe_In=1, valid[A_In] = Vbi_In as well.
  - Visible to a compare accepted on the next cycle.
  - A_In >= Words: no effect.
- Read (R, accepted):
  - Next cycle: Rd_Valid=1; Do_Out = data or care of A_In per Dcs_In; Vbo_Out = valid[A_In] if Vbe_In else 0.
  - A_In >= Words returns zeros.
  - Do_Out and Vbo_Out hold until the next read.
- Flush (F): all valid bits cleared in one cycle; data, care and payload kept.
- RST command: same effect as rst, applied at the accepting edge.
- I and codes 110/111: no effect.
- Match rule: entry i hits iff valid[i] AND for every bit b: !(care[i][b] & Mskb_In[b]) OR data[i][b]==Data_In[b].
  - A care bit of 0 means "don't care".
- Compare (C, accepted in cycle N):
  - The hit vector is snapshotted at the edge ending N. Later writes do not affect this scan (no writes are accepted during SCAN anyway).
  - Cycle N+1: Out_Valid=1 presenting the lowest-index hit.
  - Each handshake clears that bit; the next lowest hit is presented in the following cycle, giving one response per cycle with Out_Ready held high.
  - Out_Last=1 on the highest-index hit.
  - With Out_Ready=0, all Out_* signals are held stable.
- Zero hits: a single response at N+1 with Out_Hit=0, Out_Last=1, Hit_Addr/payload = 0. Every compare yields at least one response.
- After the final handshake, Cmd_Ready=1 the next cycle. No back-to-back overlap of compares.

Test Plan:
- rst for 1 cycle, then R addr 1 (Dcs=1, Vbe=1) -> Rd_Valid next cycle, Do_Out=0x00, Vbo_Out=0; all Out_* = 0.
- W addr 1 data 0x5A + DstID 3 / Weight 7 (Vbe=1, Vbi=1); W addr 1 care 0xFF (Dcs=0); C key 0x5A, Mskb 0xFF -> one response at N+1: Out_Hit=1, Hit_Addr=1, DstID_Out=3, Weight_Out=7, Out_Last=1.
- Entries 2, 5, 9 all data 0xA0 with care 0xF0; C key 0xAF, Mskb 0xFF, Out_Ready=1 -> Hit_Addr 2,5,9 on consecutive cycles, Out_Last only on 9.
- Same setup with Out_Ready low for 3 cycles on the first response -> Hit_Addr=2 held stable, Cmd_Ready=0 throughout; a W presented in SCAN is not accepted.
- F, then C key 0xAF -> single miss response: Out_Hit=0, Out_Last=1; Vbo_Out=0 on read of addr 5.
- rst asserted mid-scan after the first hit -> Out_Valid=0 next cycle, Cmd_Ready=1; C key 0xAF -> miss.
